// File: rtl/multi_bulk_endp.sv
// Multi-channel USB bulk endpoint: per-channel IN/OUT byte FIFOs whose speculative
// pointers let unACKed IN packets be retransmitted and bad OUT packets be discarded.
module multi_bulk_endp #(
  parameter int unsigned N_CHANNELS        = 2,
  parameter int unsigned FIRST_ENDP        = 1,
  parameter int unsigned IN_MAXPACKETSIZE  = 8,
  parameter int unsigned OUT_MAXPACKETSIZE = 8,
  parameter int unsigned FIFO_DEPTH        = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    usb_reset_i,
  input  logic [3:0]              endp_i,
  input  logic                    in_req_i,
  input  logic                    in_ready_i,
  input  logic                    in_ack_i,
  output logic [7:0]              in_data_o,
  output logic                    in_valid_o,
  input  logic [7:0]              out_data_i,
  input  logic                    out_valid_i,
  input  logic                    out_commit_i,
  input  logic                    out_err_i,
  output logic                    out_nak_o,
  input  logic [8*N_CHANNELS-1:0] app_in_data_i,
  input  logic [N_CHANNELS-1:0]   app_in_valid_i,
  output logic [N_CHANNELS-1:0]   app_in_ready_o,
  output logic [8*N_CHANNELS-1:0] app_out_data_o,
  output logic [N_CHANNELS-1:0]   app_out_valid_o,
  input  logic [N_CHANNELS-1:0]   app_out_ready_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] IMPS_P  = PW'(IN_MAXPACKETSIZE);
  localparam logic [PW-1:0] OMPS_P  = PW'(OUT_MAXPACKETSIZE);
  localparam logic [4:0]    FIRST_P = 5'(FIRST_ENDP);
  localparam logic [4:0]    LAST_P  = 5'(FIRST_ENDP + N_CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK} in_state_e;

  logic [7:0]    r_in_mem  [N_CHANNELS][FIFO_DEPTH];
  logic [PW-1:0] r_in_wr   [N_CHANNELS];
  logic [PW-1:0] r_in_crd  [N_CHANNELS];
  logic [PW-1:0] r_in_srd  [N_CHANNELS];
  logic [7:0]    r_out_mem [N_CHANNELS][FIFO_DEPTH];
  logic [PW-1:0] r_out_rd  [N_CHANNELS];
  logic [PW-1:0] r_out_cwr [N_CHANNELS];
  logic [PW-1:0] r_out_swr [N_CHANNELS];
  logic [N_CHANNELS-1:0] r_out_ovf;

  in_state_e     r_state;
  in_state_e     w_state_nxt;
  logic [CW-1:0] r_in_ch;
  logic [PW-1:0] r_in_len;
  logic [PW-1:0] r_in_cnt;

  logic [4:0]            w_endp_ext;
  logic                  w_sel_valid;
  logic [CW-1:0]         w_sel_ch;
  logic [PW-1:0]         w_req_occ;
  logic [PW-1:0]         w_req_len;
  logic                  w_in_start;
  logic                  w_in_adv;
  logic                  w_in_last;
  logic                  w_in_commit;
  logic [N_CHANNELS-1:0] w_in_push;
  logic [N_CHANNELS-1:0] w_out_pop;
  logic [N_CHANNELS-1:0] w_out_wr;
  logic                  w_out_room;
  logic [PW-1:0]         w_out_sel_occ;

  // Token endpoint to channel decode
  assign w_endp_ext  = {1'b0, endp_i};
  assign w_sel_valid = (w_endp_ext >= FIRST_P) && (w_endp_ext < LAST_P);
  assign w_sel_ch    = CW'(w_endp_ext - FIRST_P);

  // App-side handshakes; data is forced to zero whenever nothing is presented
  always_comb begin
    app_in_ready_o  = '0;
    w_in_push       = '0;
    app_out_valid_o = '0;
    w_out_pop       = '0;
    app_out_data_o  = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      app_in_ready_o[k]  = (r_in_wr[k] - r_in_crd[k]) < DEPTH_P;
      w_in_push[k]       = app_in_valid_i[k] & app_in_ready_o[k];
      app_out_valid_o[k] = r_out_cwr[k] != r_out_rd[k];
      w_out_pop[k]       = app_out_valid_o[k] & app_out_ready_i[k];
      if (app_out_valid_o[k])
        app_out_data_o[8*k +: 8] = r_out_mem[k][r_out_rd[k][AW-1:0]];
    end
  end

  assign w_req_occ   = r_in_wr[w_sel_ch] - r_in_crd[w_sel_ch];
  assign w_req_len   = (w_req_occ > IMPS_P) ? IMPS_P : w_req_occ;
  assign w_in_start  = in_req_i & w_sel_valid;
  assign w_in_adv    = in_valid_o & in_ready_i;
  assign w_in_last   = (r_in_cnt + PW'(1)) == r_in_len;
  assign w_in_commit = (r_state == S_WAIT_ACK) & in_ack_i & w_sel_valid;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)          r_state <= S_IDLE;
    else if (usb_reset_i) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // A new IN token always restarts the packet, which is how retransmits happen
  always_comb begin
    w_state_nxt = r_state;
    if (w_in_start) begin
      w_state_nxt = (w_req_len != '0) ? S_SEND : S_IDLE;
    end else begin
      case (r_state)
        S_SEND:     if (w_in_adv && w_in_last) w_state_nxt = S_WAIT_ACK;
        S_WAIT_ACK: if (w_in_commit) w_state_nxt = S_IDLE;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    in_valid_o = (r_state == S_SEND) && w_sel_valid;
    in_data_o  = 8'h00;
    if (in_valid_o) in_data_o = r_in_mem[r_in_ch][r_in_srd[r_in_ch][AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_in_ch  <= '0;
      r_in_len <= '0;
      r_in_cnt <= '0;
    end else if (usb_reset_i) begin
      r_in_ch  <= '0;
      r_in_len <= '0;
      r_in_cnt <= '0;
    end else if (w_in_start) begin
      r_in_ch  <= w_sel_ch;
      r_in_len <= w_req_len;
      r_in_cnt <= '0;
    end else if (w_in_adv) begin
      r_in_cnt <= r_in_cnt + PW'(1);
    end
  end

  // IN pointers: speculative read rewinds on every token, commits on ACK
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_CHANNELS; k++) begin
        r_in_wr[k]  <= '0;
        r_in_crd[k] <= '0;
        r_in_srd[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CHANNELS; k++) begin
        if (usb_reset_i) begin
          r_in_wr[k]  <= '0;
          r_in_crd[k] <= '0;
          r_in_srd[k] <= '0;
        end else begin
          if (w_in_push[k]) r_in_wr[k] <= r_in_wr[k] + PW'(1);
          if (w_in_start) begin
            r_in_srd[k] <= r_in_crd[k];
          end else if (r_in_ch == CW'(k)) begin
            if (w_in_adv)    r_in_srd[k] <= r_in_srd[k] + PW'(1);
            if (w_in_commit) r_in_crd[k] <= r_in_srd[k];
          end
        end
      end
    end
  end

  assign w_out_room    = (r_out_swr[w_sel_ch] - r_out_rd[w_sel_ch]) < DEPTH_P;
  assign w_out_sel_occ = r_out_cwr[w_sel_ch] - r_out_rd[w_sel_ch];
  assign out_nak_o     = w_sel_valid && ((DEPTH_P - w_out_sel_occ) < OMPS_P);

  always_comb begin
    w_out_wr = '0;
    for (int k = 0; k < N_CHANNELS; k++)
      w_out_wr[k] = w_sel_valid && (w_sel_ch == CW'(k)) && out_valid_i &&
                    !out_commit_i && !out_err_i && w_out_room;
  end

  // OUT pointers: bytes land speculatively and become visible only on a clean commit
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_out_ovf <= '0;
      for (int k = 0; k < N_CHANNELS; k++) begin
        r_out_rd[k]  <= '0;
        r_out_cwr[k] <= '0;
        r_out_swr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CHANNELS; k++) begin
        if (usb_reset_i) begin
          r_out_ovf[k] <= 1'b0;
          r_out_rd[k]  <= '0;
          r_out_cwr[k] <= '0;
          r_out_swr[k] <= '0;
        end else begin
          if (w_out_pop[k]) r_out_rd[k] <= r_out_rd[k] + PW'(1);
          if (w_sel_valid && (w_sel_ch == CW'(k))) begin
            if (out_commit_i) begin
              if (r_out_ovf[k]) r_out_swr[k] <= r_out_cwr[k];
              else              r_out_cwr[k] <= r_out_swr[k];
              r_out_ovf[k] <= 1'b0;
            end else if (out_err_i) begin
              r_out_swr[k] <= r_out_cwr[k];
              r_out_ovf[k] <= 1'b0;
            end else if (out_valid_i) begin
              if (w_out_room) r_out_swr[k] <= r_out_swr[k] + PW'(1);
              else            r_out_ovf[k] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Byte storage carries no reset; pointers alone define what is valid
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (w_in_push[k]) r_in_mem[k][r_in_wr[k][AW-1:0]] <= app_in_data_i[8*k +: 8];
      if (w_out_wr[k])  r_out_mem[k][r_out_swr[k][AW-1:0]] <= out_data_i;
    end
  end

endmodule

// File: tb/tb_multi_bulk_endp.sv
// Self-checking bench for multi_bulk_endp: directed corner sequences, an endpoint/NAK
// vector table, then random traffic checked against per-channel queue models.
module tb_multi_bulk_endp;

  localparam int unsigned NCH   = 2;
  localparam int unsigned FE    = 1;
  localparam int unsigned IMPS  = 8;
  localparam int unsigned OMPS  = 8;
  localparam int unsigned DEPTH = 16;
  localparam logic [NCH-1:0] ALL1 = '1;

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic             usb_reset_i = 1'b0;
  logic [3:0]       endp_i = 4'd1;
  logic             in_req_i = 1'b0;
  logic             in_ready_i = 1'b0;
  logic             in_ack_i = 1'b0;
  logic [7:0]       in_data_o;
  logic             in_valid_o;
  logic [7:0]       out_data_i = 8'h00;
  logic             out_valid_i = 1'b0;
  logic             out_commit_i = 1'b0;
  logic             out_err_i = 1'b0;
  logic             out_nak_o;
  logic [8*NCH-1:0] app_in_data_i = '0;
  logic [NCH-1:0]   app_in_valid_i = '0;
  logic [NCH-1:0]   app_in_ready_o;
  logic [8*NCH-1:0] app_out_data_o;
  logic [NCH-1:0]   app_out_valid_o;
  logic [NCH-1:0]   app_out_ready_i = '0;

  always #5 clk_i = ~clk_i;

  multi_bulk_endp #(
    .N_CHANNELS(NCH), .FIRST_ENDP(FE), .IN_MAXPACKETSIZE(IMPS),
    .OUT_MAXPACKETSIZE(OMPS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .usb_reset_i(usb_reset_i), .endp_i(endp_i),
    .in_req_i(in_req_i), .in_ready_i(in_ready_i), .in_ack_i(in_ack_i),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_commit_i(out_commit_i),
    .out_err_i(out_err_i), .out_nak_o(out_nak_o),
    .app_in_data_i(app_in_data_i), .app_in_valid_i(app_in_valid_i),
    .app_in_ready_o(app_in_ready_o), .app_out_data_o(app_out_data_o),
    .app_out_valid_o(app_out_valid_o), .app_out_ready_i(app_out_ready_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes the app has queued and not yet had ACKed, and bytes committed for the app
  logic [7:0] m_in  [NCH][$];
  logic [7:0] m_out [NCH][$];

  typedef struct {
    logic [3:0]     endp;
    logic [NCH-1:0] rdy;
    logic           exp_nak;
    logic [NCH-1:0] exp_ov;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NCH; k++) begin
      m_in[k].delete();
      m_out[k].delete();
    end
  endtask

  task automatic bus_reset();
    usb_reset_i = 1'b1;
    step();
    usb_reset_i = 1'b0;
    clear_model();
  endtask

  task automatic app_push(input int k, input logic [7:0] d);
    bit exp_rdy;
    exp_rdy = m_in[k].size() < int'(DEPTH);
    app_in_valid_i[k] = 1'b1;
    app_in_data_i[8*k +: 8] = d;
    chk("app_in_ready", app_in_ready_o[k], exp_rdy);
    step();
    app_in_valid_i = '0;
    if (exp_rdy) m_in[k].push_back(d);
  endtask

  task automatic in_xact(input int k, input bit ack);
    int len;
    len = (m_in[k].size() < int'(IMPS)) ? m_in[k].size() : int'(IMPS);
    endp_i = 4'(FE + k);
    in_req_i = 1'b1;
    step();
    in_req_i = 1'b0;
    chk("in_start_valid", in_valid_o, len > 0);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("in_hold_valid", in_valid_o, 1'b1);
      end
      chk("in_data", in_data_o, m_in[k][i]);
      in_ready_i = 1'b1;
      step();
      in_ready_i = 1'b0;
    end
    chk("in_end_valid", in_valid_o, 1'b0);
    if (ack) begin
      in_ack_i = 1'b1;
      step();
      in_ack_i = 1'b0;
      repeat (len) void'(m_in[k].pop_front());
    end
  endtask

  task automatic out_pkt(input logic [3:0] endp, input int n, input bit commit, input int base);
    logic [7:0] pend [$];
    logic [7:0] d;
    bit hit;
    bit ovf;
    int k;
    hit = (int'(endp) >= int'(FE)) && (int'(endp) < int'(FE + NCH));
    k = int'(endp) - int'(FE);
    endp_i = endp;
    #1;
    if (hit) chk("out_nak", out_nak_o, (int'(DEPTH) - m_out[k].size()) < int'(OMPS));
    else     chk("out_nak_unsel", out_nak_o, 1'b0);
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = (base < 0) ? 8'($urandom) : 8'(base + i);
      out_data_i = d;
      out_valid_i = 1'b1;
      step();
      out_valid_i = 1'b0;
      if (hit) begin
        if (m_out[k].size() + pend.size() < int'(DEPTH)) pend.push_back(d);
        else ovf = 1'b1;
      end
    end
    out_commit_i = commit;
    out_err_i = !commit;
    step();
    out_commit_i = 1'b0;
    out_err_i = 1'b0;
    if (hit && commit && !ovf) foreach (pend[i]) m_out[k].push_back(pend[i]);
  endtask

  task automatic app_drain(input int k, input int cycles, input bit all_ready);
    bit r;
    for (int c = 0; c < cycles; c++) begin
      r = all_ready ? 1'b1 : 1'($urandom_range(0, 1));
      app_out_ready_i[k] = r;
      chk("app_out_valid", app_out_valid_o[k], m_out[k].size() > 0);
      if (m_out[k].size() > 0) chk("app_out_data", app_out_data_o[8*k +: 8], m_out[k][0]);
      step();
      if (r && m_out[k].size() > 0) void'(m_out[k].pop_front());
    end
    app_out_ready_i = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int op;
    int k;

    tbl[0] = '{4'd2,  2'b00, 1'b1, 2'b10};
    tbl[1] = '{4'd1,  2'b00, 1'b0, 2'b10};
    tbl[2] = '{4'd0,  2'b00, 1'b0, 2'b10};
    tbl[3] = '{4'd3,  2'b01, 1'b0, 2'b10};
    tbl[4] = '{4'd15, 2'b00, 1'b0, 2'b10};
    tbl[5] = '{4'd2,  2'b10, 1'b1, 2'b10};
    tbl[6] = '{4'd2,  2'b00, 1'b0, 2'b10};
    tbl[7] = '{4'd1,  2'b00, 1'b0, 2'b10};

    // Power-on reset values
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_in_valid", in_valid_o, 1'b0);
    chk("rst_in_data", in_data_o, 8'h00);
    chk("rst_out_nak", out_nak_o, 1'b0);
    chk("rst_app_out_valid", app_out_valid_o, '0);
    chk("rst_app_out_data", app_out_data_o, '0);
    chk("rst_app_in_ready", app_in_ready_o, ALL1);
    rstn_i = 1'b1;
    step();

    // Ten bytes on channel 0 go out as 8 then 2
    bus_reset();
    for (int i = 0; i < 10; i++) app_push(0, 8'(i));
    in_xact(0, 1'b1);
    in_xact(0, 1'b1);

    // Full FIFO, no ACK: retransmit identical bytes and keep app stalled
    bus_reset();
    for (int i = 0; i < 16; i++) app_push(0, 8'(8'h40 + i));
    chk("full_rdy", app_in_ready_o[0], 1'b0);
    in_xact(0, 1'b0);
    chk("noack_rdy", app_in_ready_o[0], 1'b0);
    in_xact(0, 1'b0);
    app_push(0, 8'hEE);
    in_xact(0, 1'b1);
    chk("ack_rdy", app_in_ready_o[0], 1'b1);

    // Bad OUT packet is discarded, resend is delivered in order
    bus_reset();
    out_pkt(4'd2, 8, 1'b0, 8'h80);
    chk("err_no_valid", app_out_valid_o[1], 1'b0);
    out_pkt(4'd2, 8, 1'b1, 8'h80);
    chk("commit_valid", app_out_valid_o[1], 1'b1);
    app_drain(1, 12, 1'b1);
    chk("drain_empty", app_out_valid_o[1], 1'b0);

    // NAK decode table with channel 1 holding 9 bytes
    bus_reset();
    out_pkt(4'd2, 8, 1'b1, 8'h10);
    out_pkt(4'd2, 1, 1'b1, 8'h20);
    for (int i = 0; i < 8; i++) begin
      endp_i = tbl[i].endp;
      app_out_ready_i = tbl[i].rdy;
      #1;
      chk("tbl_nak", out_nak_o, tbl[i].exp_nak);
      chk("tbl_out_valid", app_out_valid_o, tbl[i].exp_ov);
      step();
    end
    app_out_ready_i = '0;

    // USB reset in the middle of SEND flushes everything
    bus_reset();
    for (int i = 0; i < 4; i++) begin
      app_push(0, 8'(8'h30 + i));
      app_push(1, 8'(8'h50 + i));
    end
    out_pkt(4'd1, 3, 1'b1, 8'h60);
    out_pkt(4'd2, 3, 1'b1, 8'h70);
    endp_i = 4'd1;
    in_req_i = 1'b1;
    step();
    in_req_i = 1'b0;
    chk("send_valid", in_valid_o, 1'b1);
    in_ready_i = 1'b1;
    step();
    in_ready_i = 1'b0;
    usb_reset_i = 1'b1;
    step();
    usb_reset_i = 1'b0;
    clear_model();
    chk("usbrst_in_valid", in_valid_o, 1'b0);
    chk("usbrst_out_valid", app_out_valid_o, '0);
    chk("usbrst_in_ready", app_in_ready_o, ALL1);
    in_req_i = 1'b1;
    step();
    in_req_i = 1'b0;
    chk("usbrst_empty_req", in_valid_o, 1'b0);

    // rstn_i asserted mid-transaction leaves nothing half-committed
    for (int i = 0; i < 5; i++) app_push(1, 8'(8'hA0 + i));
    endp_i = 4'd1;
    out_data_i = 8'h11;
    out_valid_i = 1'b1;
    repeat (3) step();
    out_valid_i = 1'b0;
    endp_i = 4'd2;
    in_req_i = 1'b1;
    step();
    in_req_i = 1'b0;
    in_ready_i = 1'b1;
    repeat (2) step();
    in_ready_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_in_valid", in_valid_o, 1'b0);
    chk("arst_in_ready", app_in_ready_o, ALL1);
    chk("arst_out_valid", app_out_valid_o, '0);
    @(posedge clk_i);
    #1 rstn_i = 1'b1;
    step();
    clear_model();
    endp_i = 4'd1;
    out_commit_i = 1'b1;
    step();
    out_commit_i = 1'b0;
    chk("arst_no_commit", app_out_valid_o, '0);
    endp_i = 4'd2;
    in_ack_i = 1'b1;
    step();
    in_ack_i = 1'b0;
    in_req_i = 1'b1;
    step();
    in_req_i = 1'b0;
    chk("arst_in_flushed", in_valid_o, 1'b0);
    chk("arst_in_ready2", app_in_ready_o, ALL1);

    // Random traffic against the queue model
    bus_reset();
    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 5);
      k  = $urandom_range(0, NCH - 1);
      case (op)
        0, 5: repeat ($urandom_range(1, 12)) app_push(k, 8'($urandom));
        1: in_xact(k, $urandom_range(0, 3) != 0);
        2: out_pkt(4'($urandom_range(0, 3)), $urandom_range(1, OMPS), $urandom_range(0, 3) != 0, -1);
        3: app_drain(k, $urandom_range(1, 10), 1'b0);
        default: begin
          endp_i = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'(FE + NCH + $urandom_range(0, 5));
          in_req_i = 1'b1;
          step();
          in_req_i = 1'b0;
          chk("stray_req_valid", in_valid_o, 1'b0);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_bulk_endp.md
MULTI_BULK_ENDP -- requirements
Module: multi_bulk_endp

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 2, number of bulk channels (1..4).
REQ-002 SHALL have parameter FIRST_ENDP, default 1, endpoint number of channel 0; channel k maps to endpoint FIRST_ENDP+k.
REQ-003 SHALL have parameters IN_MAXPACKETSIZE and OUT_MAXPACKETSIZE, default 8, max bytes per IN/OUT packet (8, 16, 32 or 64).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, bytes per direction per channel; power of 2, at least 2*max(IN_MAXPACKETSIZE, OUT_MAXPACKETSIZE).
REQ-005 SHALL have ports clk_i (in, 1, single clock; 12MHz*BIT_SAMPLES) and rstn_i (in, 1): one clock; reset is asynchronous and active-low.
REQ-006 SHALL have usb_reset_i (in, 1): USB bus reset, flushes all channels.
REQ-007 SHALL have endp_i (in, 4): endpoint of the current token.
REQ-008 SHALL have in_req_i (in, 1): one-cycle pulse, IN token for endp_i.
REQ-009 SHALL have in_ready_i (in, 1): one-cycle pulse, SIE consumed in_data_o.
REQ-010 SHALL have in_ack_i (in, 1): one-cycle pulse, host ACKed the last IN packet.
REQ-011 SHALL have in_data_o (out, 8) and in_valid_o (out, 1): current IN byte; in_valid_o low means no more bytes in packet.
REQ-012 SHALL have out_data_i (in, 8) and out_valid_i (in, 1): one-cycle strobe per received OUT byte.
REQ-013 SHALL have out_commit_i (in, 1) and out_err_i (in, 1): end-of-packet pulses, good CRC / bad packet.
REQ-014 SHALL have out_nak_o (out, 1): selected channel cannot accept a full OUT packet.
REQ-015 SHALL have app_in_data_i (in, 8*N_CHANNELS), app_in_valid_i (in, N_CHANNELS), app_in_ready_o (out, N_CHANNELS): per-channel IN byte stream, byte k at bits [8k+7:8k].
REQ-016 SHALL have app_out_data_o (out, 8*N_CHANNELS), app_out_valid_o (out, N_CHANNELS), app_out_ready_i (in, N_CHANNELS): per-channel OUT byte stream.

Function
REQ-017 Channel selected SHALL be endp_i-FIRST_ENDP; endp_i outside range selects none: in_valid_o=0, out_nak_o=0, SIE strobes ignored.
REQ-018 Each channel SHALL hold an IN FIFO (committed read ptr, speculative read ptr, write ptr) and an OUT FIFO (read ptr, committed write ptr, speculative write ptr); pointers log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH.
REQ-019 app_in_ready_o[k] SHALL be 1 when (write ptr - committed read ptr) < FIFO_DEPTH; byte written when valid&ready same cycle.
REQ-020 app_out_valid_o[k] SHALL be 1 when committed write ptr != read ptr; data held stable until valid&ready; uncommitted bytes never visible.
REQ-021 Shared IN FSM states IDLE, SEND, WAIT_ACK; on in_req_i every channel's speculative read ptr SHALL rewind to its committed read ptr first (retransmit).
REQ-022 On in_req_i, IN FSM SHALL latch channel and len = min(occupancy, IN_MAXPACKETSIZE); len>0 -> SEND, len=0 -> stay IDLE (in_valid_o=0, SIE sends NAK).
REQ-023 In SEND, in_valid_o=1 from the cycle after in_req_i; each in_ready_i advances speculative ptr; after len bytes in_valid_o=0 and -> WAIT_ACK.
REQ-024 in_ack_i in WAIT_ACK SHALL set committed read ptr to speculative ptr and go IDLE; in_ack_i in other states ignored.
REQ-025 out_valid_i SHALL write at speculative write ptr if (spec ptr - read ptr) < FIFO_DEPTH; otherwise byte dropped and packet overflow flag set.
REQ-026 out_commit_i SHALL copy spec ptr to committed ptr unless overflow flag set; out_err_i or overflow SHALL rewind spec ptr to committed ptr; flag cleared either way.
REQ-027 out_nak_o SHALL be combinational: FIFO_DEPTH - (committed write ptr - read ptr) < OUT_MAXPACKETSIZE for the selected channel.
REQ-028 App-side and SIE-side operations on the same FIFO in the same cycle SHALL both take effect.
REQ-029 usb_reset_i SHALL have highest priority: all pointers zeroed, flags cleared, IN FSM to IDLE, in the same edge.

Reset
REQ-030 While rstn_i low: all pointers 0, IN FSM IDLE, overflow flags 0, in_valid_o=0, in_data_o=0, out_nak_o=0, app_out_valid_o=0, app_out_data_o=0, app_in_ready_o all 1.
REQ-031 Reset assertion mid-transaction SHALL abort it with no partial commit on release.

Verification
REQ-032 App writes 10 bytes 0x00..0x09 to channel 0; in_req_i endp 1 -> 8 bytes 0x00..0x07 with in_valid_o; in_ack_i; next in_req_i -> 0x08,0x09.
REQ-033 IN packet sent, no in_ack_i, in_req_i again -> same 8 bytes retransmitted; app_in_ready_o stays 0 when FIFO was full.
REQ-034 OUT 8 bytes to endp 2 + out_err_i -> app_out_valid_o[1] stays 0; resend + out_commit_i -> 8 bytes delivered in order.
REQ-035 Channel 1 OUT FIFO holds 9 of 16 bytes, app_out_ready_i=0 -> out_nak_o=1 when endp_i=2, 0 when endp_i=1.
REQ-036 usb_reset_i during SEND with bytes in all FIFOs -> next cycle in_valid_o=0, app_out_valid_o=0, app_in_ready_o all 1.
